// File: rtl/risc_pkg.sv
// Shared opcode, function-select, state and field definitions for the
// 16-bit RISC control path.
package risc_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_LDI  = 4'h9;
    localparam logic [3:0] OP_LD   = 4'hA;
    localparam logic [3:0] OP_ST   = 4'hB;
    localparam logic [3:0] OP_BZ   = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_JAL  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] FS_ADD = 3'b000;
    localparam logic [2:0] FS_SUB = 3'b001;
    localparam logic [2:0] FS_AND = 3'b010;
    localparam logic [2:0] FS_OR  = 3'b011;
    localparam logic [2:0] FS_XOR = 3'b100;
    localparam logic [2:0] FS_NOT = 3'b101;
    localparam logic [2:0] FS_SHL = 3'b110;
    localparam logic [2:0] FS_SHR = 3'b111;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int DA_MSB = 11;
    localparam int DA_LSB = 8;
    localparam int AA_MSB = 7;
    localparam int AA_LSB = 4;
    localparam int BA_MSB = 3;
    localparam int BA_LSB = 0;
    localparam int PC_W   = 6;

    typedef struct packed {
        logic [2:0] fs;
        logic       rw;
        logic       mb;
        logic       md;
        logic       mj;
        logic       mm;
        logic       mk;
        logic       a_thru;
        logic       b_thru;
        logic       mw;
    } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of the instruction register into the datapath control
// bundle; outside EXEC only the memory-address mux select is driven.
module instr_decoder
    import risc_pkg::*;
(
    input  logic [15:0] i_ir,
    input  state_t      i_state,
    output ctrl_t       o_ctrl
);

    logic [3:0] w_op;
    logic [3:0] w_fs_full;

    assign w_op      = i_ir[OP_MSB:OP_LSB];
    assign w_fs_full = w_op - 4'd1;

    always_comb begin
        o_ctrl = '0;
        if (i_state != ST_EXEC) begin
            o_ctrl.mm = 1'b1;
        end else begin
            case (w_op)
                OP_ADD, OP_SUB, OP_AND, OP_OR,
                OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
                    o_ctrl.fs = w_fs_full[2:0];
                    o_ctrl.rw = 1'b1;
                end
                OP_LDI: begin
                    o_ctrl.mb     = 1'b1;
                    o_ctrl.b_thru = 1'b1;
                    o_ctrl.rw     = 1'b1;
                end
                OP_LD: begin
                    o_ctrl.md = 1'b1;
                    o_ctrl.rw = 1'b1;
                end
                OP_ST: begin
                    o_ctrl.mk = 1'b1;
                    o_ctrl.mw = 1'b1;
                end
                OP_BZ: begin
                    o_ctrl.mk     = 1'b1;
                    o_ctrl.a_thru = 1'b1;
                end
                OP_JAL: begin
                    o_ctrl.mj = 1'b1;
                    o_ctrl.rw = 1'b1;
                end
                default: o_ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Two-cycle FETCH/EXEC sequencer: owns PC, PC_prev, IR and the retired count,
// and exposes the decoded datapath controls.
//   state | meaning
//   FETCH | latch IR from mem, PC_prev <= PC, PC <= PC+1
//   EXEC  | drive decoded controls, apply branch/jump, count retirement
//   HALT  | parked until reset, PC frozen
module control_unit
    import risc_pkg::*;
#(
    parameter int nBit = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [nBit-1:0] mem,
    input  logic            zero_flag,
    input  logic [5:0]      A,
    output logic [5:0]      PC,
    output logic [5:0]      PC_prev,
    output logic [3:0]      DA,
    output logic [3:0]      AA,
    output logic [3:0]      BA,
    output logic [2:0]      FS,
    output logic            RW,
    output logic            MB,
    output logic            MD,
    output logic            MJ,
    output logic            MM,
    output logic            MK,
    output logic            A_thru,
    output logic            B_thru,
    output logic            MW,
    output logic            halted,
    output logic [15:0]     retired
);

    state_t          r_state;
    logic [nBit-1:0] r_ir;
    logic [5:0]      r_pc;
    logic [5:0]      r_pc_prev;
    logic [15:0]     r_retired;
    logic            r_halted;
    ctrl_t           w_ctrl;
    logic [3:0]      w_op;
    logic [5:0]      w_imm6;

    assign w_op   = r_ir[OP_MSB:OP_LSB];
    assign w_imm6 = r_ir[5:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_FETCH;
            r_ir      <= '0;
            r_pc      <= '0;
            r_pc_prev <= '0;
            r_retired <= '0;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    r_ir      <= mem;
                    r_pc_prev <= r_pc;
                    r_pc      <= r_pc + 6'd1;
                    r_state   <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_retired <= r_retired + 16'd1;
                    case (w_op)
                        OP_BZ:   if (zero_flag) r_pc <= w_imm6;
                        OP_JMP:  r_pc <= w_imm6;
                        OP_JAL:  r_pc <= A;
                        default: r_pc <= r_pc;
                    endcase
                    if (w_op == OP_HALT) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state  <= ST_FETCH;
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    instr_decoder u_dec (
        .i_ir    (r_ir[15:0]),
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    assign PC      = r_pc;
    assign PC_prev = r_pc_prev;
    assign DA      = r_ir[DA_MSB:DA_LSB];
    assign AA      = r_ir[AA_MSB:AA_LSB];
    assign BA      = r_ir[BA_MSB:BA_LSB];
    assign FS      = w_ctrl.fs;
    assign RW      = w_ctrl.rw;
    assign MB      = w_ctrl.mb;
    assign MD      = w_ctrl.md;
    assign MJ      = w_ctrl.mj;
    assign MM      = w_ctrl.mm;
    assign MK      = w_ctrl.mk;
    assign A_thru  = w_ctrl.a_thru;
    assign B_thru  = w_ctrl.b_thru;
    assign MW      = w_ctrl.mw;
    assign halted  = r_halted;
    assign retired = r_retired;

endmodule
